// File: rtl/skinny_sbox_layer_ctrl.sv
// Streams the 16 nibbles of a two-share Skinny-64 state through one shared
// pipelined masked S-box and writes each result back in place by nibble index.
module skinny_sbox_layer_ctrl #(
  parameter int SBOX_LAT = 2,
  parameter int NIB      = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] state_in_s0,
  input  logic [63:0] state_in_s1,
  input  logic        rnd_valid,
  input  logic [63:0] rnd_data,
  output logic        rnd_ready,
  output logic [3:0]  sbox_x_s0,
  output logic [3:0]  sbox_x_s1,
  output logic [63:0] sbox_fresh,
  input  logic [3:0]  sbox_y_s0,
  input  logic [3:0]  sbox_y_s1,
  output logic        busy,
  output logic        done,
  output logic [63:0] state_out_s0,
  output logic [63:0] state_out_s1
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t      state, state_nx;
  logic [63:0] work_s0, work_s1;
  logic [4:0]  iss, wr;
  logic        tok_vld_p [SBOX_LAT];
  logic [3:0]  tok_idx_p [SBOX_LAT];

  logic        hs, cap, wb, last_iss, all_wr;
  logic [5:0]  rd_base, wb_base;

  assign cap      = (state == IDLE) && start;
  assign hs       = (state == ISSUE) && rnd_valid;
  assign last_iss = (iss == 5'(NIB - 1));
  assign all_wr   = (wr == 5'(NIB));
  assign rd_base  = {iss[3:0], 2'b00};
  assign wb       = tok_vld_p[SBOX_LAT-1];
  assign wb_base  = {tok_idx_p[SBOX_LAT-1], 2'b00};

  // Shares are only presented on a handshake so bubbles never expose state
  assign rnd_ready    = (state == ISSUE);
  assign sbox_x_s0    = hs ? work_s0[rd_base +: 4] : 4'd0;
  assign sbox_x_s1    = hs ? work_s1[rd_base +: 4] : 4'd0;
  assign sbox_fresh   = hs ? rnd_data : 64'd0;
  assign busy         = (state != IDLE);
  assign done         = (state == DRAIN) && all_wr;
  assign state_out_s0 = work_s0;
  assign state_out_s1 = work_s1;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = ISSUE;
      ISSUE:   if (hs && last_iss) state_nx = DRAIN;
      DRAIN:   if (all_wr) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      iss     <= 5'd0;
      wr      <= 5'd0;
      work_s0 <= 64'd0;
      work_s1 <= 64'd0;
      for (int i = 0; i < SBOX_LAT; i++) begin
        tok_vld_p[i] <= 1'b0;
        tok_idx_p[i] <= 4'd0;
      end
    end else begin
      state <= state_nx;
      // Token pipeline mirrors the enable-less S-box pipeline: always shifts
      tok_vld_p[0] <= hs;
      tok_idx_p[0] <= iss[3:0];
      for (int i = 1; i < SBOX_LAT; i++) begin
        tok_vld_p[i] <= tok_vld_p[i-1];
        tok_idx_p[i] <= tok_idx_p[i-1];
      end
      if (cap) begin
        work_s0 <= state_in_s0;
        work_s1 <= state_in_s1;
        iss     <= 5'd0;
        wr      <= 5'd0;
      end else begin
        if (hs) iss <= iss + 5'd1;
        if (wb) begin
          work_s0[wb_base +: 4] <= sbox_y_s0;
          work_s1[wb_base +: 4] <= sbox_y_s1;
          wr                    <= wr + 5'd1;
        end
      end
    end
  end

endmodule

// File: doc/skinny_sbox_layer_ctrl.md
# skinny_sbox_layer_ctrl

Sequencer that applies the masked Skinny-64 S-box layer to a full 64-bit, two-share state by streaming its 16 nibbles through one shared, pipelined, first-order masked S-box instance (two shares, 64 fresh bits per evaluation, fixed pipeline latency). It sits between the round-state register and the S-box datapath. It consumes the randomness source through a valid/ready handshake, tracks in-flight evaluations with a token pipeline, and writes results back by nibble index. It signals completion of the whole layer with a one-cycle `done` pulse.

## Interface
- `SBOX_LAT`, default 2: clock cycles from driving `sbox_x_*`/`sbox_fresh` to the matching `sbox_y_*`. Must be ≥ 1.
- `NIB`, default 16: nibbles per layer. Fixed at 16 for Skinny-64.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request one S-box layer. Sampled only in IDLE.
- `state_in_s0`, `state_in_s1` in 64 each: input shares. Captured on accepted `start`.
- `rnd_valid` in 1: `rnd_data` is valid.
- `rnd_data` in 64: fresh randomness for one S-box evaluation.
- `rnd_ready` out 1: the controller consumes `rnd_data` this cycle.
- `sbox_x_s0`, `sbox_x_s1` out 4 each: S-box input shares.
- `sbox_fresh` out 64: S-box randomness input.
- `sbox_y_s0`, `sbox_y_s1` in 4 each: S-box output shares.
- `busy` out 1: a layer is in progress.
- `done` out 1: one-cycle pulse when the layer is complete.
- `state_out_s0`, `state_out_s1` out 64 each: result shares. Valid from `done` until the next accepted `start`.

## Operation
- FSM states are IDLE, ISSUE and DRAIN.
- IDLE:
  - `start`=1 captures both input shares into the working registers, clears the issue counter `iss` (5 bits) and the write counter `wr` (5 bits), and moves to ISSUE.
  - `start` is ignored in every other state.
- ISSUE:
  - `rnd_ready`=1.
  - A handshake (`rnd_valid`&`rnd_ready`) issues nibble `iss`:
    - `sbox_x_s0` = working_s0[4·iss+3:4·iss]
    - `sbox_x_s1` = working_s1[4·iss+3:4·iss]
    - `sbox_fresh` = `rnd_data`
    - a token {valid=1, idx=iss} is pushed into a SBOX_LAT-deep shift register, and `iss` increments.
  - Without a handshake, `sbox_x_*` = 0, `sbox_fresh` = 0, and a token with valid=0 is pushed. This is a stall bubble.
  - After the handshake that issues nibble 15, the FSM moves to DRAIN.
- Token pipeline:
  - The token shift register advances every cycle unconditionally, because the S-box pipeline has no enable.
  - When the token at the output is valid, `sbox_y_s0`/`sbox_y_s1` are written into working_s0/s1 at nibble idx, and `wr` increments.
- DRAIN:
  - `rnd_ready`=0, and `sbox_x_*`/`sbox_fresh` = 0.
  - When `wr` reaches 16, the FSM asserts `done` for one cycle, `busy` falls, and the FSM returns to IDLE.
- Each `rnd_data` word is used for exactly one evaluation. No randomness word is reused or shared between nibbles.
- The working registers drive `state_out_*`.
- In-place overwrite is safe: nibble i is read only at its issue, and written only SBOX_LAT or more cycles later.
- Reset behaviour:
  - Asserting `rst_n`=0 at any time forces IDLE, clears all tokens, counters and working registers, and drives every output to 0.
  - S-box results still in flight are discarded, because their tokens were cleared.

## Timing
- Reset values:
  - `rnd_ready`, `busy`, `done` = 0
  - `sbox_x_*`, `sbox_fresh` = 0
  - `state_out_*` = 0
- `start` is sampled at edge 0. ISSUE is active in cycle 1. `busy`=1 from cycle 1 through the cycle in which `done`=1.
- With `rnd_valid` held at 1:
  - nibbles issue in cycles 1..16;
  - nibble k's result is written at the end of cycle k+1+SBOX_LAT;
  - `done` is high in cycle 17+SBOX_LAT, which is cycle 19 for SBOX_LAT=2.
- Each cycle of `rnd_valid`=0 during ISSUE delays `done` by exactly one cycle.
- The earliest next `start` is accepted in the cycle after `done`.
- `sbox_x_*` and `sbox_fresh` are combinational from registered state and `rnd_data`. They have no extra register stage.

## Test plan
- Reset, then `start` with s0=0x0123456789ABCDEF, s1=0, and `rnd_valid`=1 constantly:
  - `done` appears in cycle 19;
  - s0^s1 equals the Skinny-64 S-box applied to every nibble of 0x0123456789ABCDEF;
  - exactly 16 `rnd_ready` handshakes occur.
- Random masking: s1 random, s0 = plaintext^s1, random `rnd_data`:
  - the unmasked result matches the reference S-box layer;
  - the individual shares differ from run to run.
- `rnd_valid` toggled 1,0,1,0…:
  - `done` arrives 15 cycles later than in the continuous case;
  - the result is identical;
  - `sbox_fresh`=0 in every bubble cycle.
- `start` pulsed during ISSUE and during DRAIN:
  - it is ignored;
  - exactly one `done`, and counters are unaffected.
- `rst_n` dropped in cycle 8 of a run, then a fresh `start` with new data:
  - all outputs read 0 during reset;
  - the second run's result is correct, with no writes from stale tokens.
- Back-to-back: `start` asserted in the cycle after `done`:
  - the second layer starts in the next cycle;
  - `state_out` of the first run remains valid up to the second `start`.
